// File: rtl/csr_pkg.sv
// Shared CSR constants and sequencer state type for the machine-mode trap logic.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MIE_MEIE       = 11;

  typedef enum logic [3:0] {
    IDLE,
    T_ST,
    T_IE,
    T_EPC,
    T_WST,
    MR_EPC,
    MR_ST,
    MR_WST,
    REDIR
  } seq_state_e;

  // mstatus image written on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] st);
    logic [31:0] r;
    r = st;
    r[MSTATUS_MPIE] = st[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus image written on mret: MIE <- MPIE, MPIE <- 1, MPP <- U.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] st);
    logic [31:0] r;
    r = st;
    r[MSTATUS_MIE]  = st[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_seq.sv
// Trap entry / mret sequencer driving the machine-mode CSR file port.
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC       = 32'h0000_0100,
  parameter int unsigned RECHECK_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        mret,
  input  logic [31:0] pc,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_rd,
  output logic        csr_wr,
  input  logic [31:0] csr_rdata,
  output logic        stall,
  output logic        busy,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  seq_state_e  state, state_n;
  logic [31:0] pc_q, st_q, epc_q;
  logic [7:0]  gap_cnt;
  logic        accept, reject;

  assign accept = rst && (state == IDLE) && (mret || (irq && (gap_cnt == '0)));
  assign reject = ((state == T_ST) && !csr_rdata[MSTATUS_MIE]) ||
                  ((state == T_IE) && !csr_rdata[MIE_MEIE]);
  assign stall  = busy || accept;

  // Next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mret) state_n = MR_EPC;
               else if (irq && (gap_cnt == '0)) state_n = T_ST;
      T_ST:    state_n = csr_rdata[MSTATUS_MIE] ? T_IE : IDLE;
      T_IE:    state_n = csr_rdata[MIE_MEIE] ? T_EPC : IDLE;
      T_EPC:   state_n = T_WST;
      T_WST:   state_n = REDIR;
      MR_EPC:  state_n = MR_ST;
      MR_ST:   state_n = MR_WST;
      MR_WST:  state_n = REDIR;
      REDIR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, captured CSR values, gap counter and registered port outputs.
  // Outputs are decoded from state_n so they line up with the state they belong to;
  // the mret write image is built from csr_rdata because st_q loads on that same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc_q        <= '0;
      st_q        <= '0;
      epc_q       <= '0;
      gap_cnt     <= '0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      csr_rd      <= 1'b0;
      csr_wr      <= 1'b0;
      busy        <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      if (accept) pc_q <= pc;
      if ((state == T_ST) || (state == MR_ST)) st_q <= csr_rdata;
      if (state == MR_EPC) epc_q <= csr_rdata;
      if (reject) gap_cnt <= 8'(RECHECK_GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;

      csr_addr    <= '0;
      csr_wdata   <= '0;
      csr_rd      <= 1'b0;
      csr_wr      <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      busy        <= (state_n != IDLE);
      unique case (state_n)
        T_ST:   begin csr_rd <= 1'b1; csr_addr <= CSR_MSTATUS; end
        T_IE:   begin csr_rd <= 1'b1; csr_addr <= CSR_MIE; end
        T_EPC:  begin csr_wr <= 1'b1; csr_addr <= CSR_MEPC; csr_wdata <= pc_q; end
        T_WST:  begin csr_wr <= 1'b1; csr_addr <= CSR_MSTATUS; csr_wdata <= trap_mstatus(st_q); end
        MR_EPC: begin csr_rd <= 1'b1; csr_addr <= CSR_MEPC; end
        MR_ST:  begin csr_rd <= 1'b1; csr_addr <= CSR_MSTATUS; end
        MR_WST: begin csr_wr <= 1'b1; csr_addr <= CSR_MSTATUS; csr_wdata <= mret_mstatus(csr_rdata); end
        REDIR:  begin
          redirect    <= 1'b1;
          redirect_pc <= (state == T_WST) ? MTVEC : epc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: CSR file model plus a transaction-level expectation queue.
module tb_csr_trap_seq;

  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          RG = 8;

  logic        clk = 1'b0;
  logic        rst, irq, mret;
  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, redirect_pc;
  logic        csr_rd, csr_wr, stall, busy, redirect;

  csr_trap_seq #(.MTVEC(TV), .RECHECK_GAP(RG)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mret(mret), .pc(pc),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rd(csr_rd), .csr_wr(csr_wr),
    .csr_rdata(csr_rdata), .stall(stall), .busy(busy),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // CSR file model: combinational read, write commits on the edge
  logic [31:0] m_ms = '0, m_mie = '0, m_mepc = '0;
  logic        ld = 1'b0;
  logic [31:0] ld_ms, ld_mie, ld_mepc;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = m_ms;
      12'h304: csr_rdata = m_mie;
      12'h341: csr_rdata = m_mepc;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wr) begin
      case (csr_addr)
        12'h300: m_ms   <= csr_wdata;
        12'h304: m_mie  <= csr_wdata;
        12'h341: m_mepc <= csr_wdata;
        default: ;
      endcase
    end else if (ld) begin
      m_ms <= ld_ms; m_mie <= ld_mie; m_mepc <= ld_mepc;
    end
  end

  typedef struct {
    logic        rd, wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stl, bsy, rdr;
    logic [31:0] rpc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errs = 0;
  logic [31:0] e_ms, e_mie, e_mepc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] f_trap_ms(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  function automatic logic [31:0] f_mret_ms(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (s[7] ? 32'h8 : 32'h0) | 32'h80;
  endfunction

  task automatic push(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic s, input logic b, input logic r, input logic [31:0] rp);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
    e.stl = s; e.bsy = b; e.rdr = r; e.rpc = rp;
    q.push_back(e);
  endtask

  task automatic push_idle();   push(0, 0, 12'h0, 32'h0, 0, 0, 0, 32'h0); endtask
  task automatic push_accept(); push(0, 0, 12'h0, 32'h0, 1, 0, 0, 32'h0); endtask

  // Interrupt acceptance: read mstatus, read mie, then save pc and enter the handler
  task automatic predict_trap(input logic [31:0] p);
    push_accept();
    push(1, 0, 12'h300, 32'h0, 1, 1, 0, 32'h0);
    if (!e_ms[3]) return;
    push(1, 0, 12'h304, 32'h0, 1, 1, 0, 32'h0);
    if (!e_mie[11]) return;
    push(0, 1, 12'h341, p, 1, 1, 0, 32'h0);
    push(0, 1, 12'h300, f_trap_ms(e_ms), 1, 1, 0, 32'h0);
    push(0, 0, 12'h0, 32'h0, 1, 1, 1, TV);
    e_mepc = p;
    e_ms   = f_trap_ms(e_ms);
  endtask

  task automatic predict_mret();
    push_accept();
    push(1, 0, 12'h341, 32'h0, 1, 1, 0, 32'h0);
    push(1, 0, 12'h300, 32'h0, 1, 1, 0, 32'h0);
    push(0, 1, 12'h300, f_mret_ms(e_ms), 1, 1, 0, 32'h0);
    push(0, 0, 12'h0, 32'h0, 1, 1, 1, e_mepc);
    e_ms = f_mret_ms(e_ms);
  endtask

  // Apply the queued cycles; requests drop right after the listed cycle indices
  task automatic play(input string tag, input int dm, input int di);
    int n;
    exp_t e;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      e = q[i];
      @(negedge clk);
      chk($sformatf("%s[%0d].stall", tag, i), {31'b0, stall}, {31'b0, e.stl});
      chk($sformatf("%s[%0d].busy", tag, i), {31'b0, busy}, {31'b0, e.bsy});
      chk($sformatf("%s[%0d].rd", tag, i), {31'b0, csr_rd}, {31'b0, e.rd});
      chk($sformatf("%s[%0d].wr", tag, i), {31'b0, csr_wr}, {31'b0, e.wr});
      chk($sformatf("%s[%0d].redir", tag, i), {31'b0, redirect}, {31'b0, e.rdr});
      if (e.rd || e.wr) chk($sformatf("%s[%0d].addr", tag, i), {20'b0, csr_addr}, {20'b0, e.addr});
      if (e.wr) chk($sformatf("%s[%0d].wdata", tag, i), csr_wdata, e.wdata);
      if (e.rdr) chk($sformatf("%s[%0d].rpc", tag, i), redirect_pc, e.rpc);
      @(posedge clk); #1;
      if (i == dm) mret = 1'b0;
      if (i == di) irq = 1'b0;
    end
    q.delete();
  endtask

  task automatic load(input logic [31:0] ms, input logic [31:0] mie, input logic [31:0] epc);
    ld_ms = ms; ld_mie = mie; ld_mepc = epc; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    e_ms = ms; e_mie = mie; e_mepc = epc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_csrs(input string tag);
    chk({tag, ".mstatus"}, m_ms, e_ms);
    chk({tag, ".mepc"}, m_mepc, e_mepc);
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, ".stall"}, {31'b0, stall}, 32'h0);
    chk({tag, ".busy"}, {31'b0, busy}, 32'h0);
    chk({tag, ".rd"}, {31'b0, csr_rd}, 32'h0);
    chk({tag, ".wr"}, {31'b0, csr_wr}, 32'h0);
    chk({tag, ".redir"}, {31'b0, redirect}, 32'h0);
    chk({tag, ".addr"}, {20'b0, csr_addr}, 32'h0);
    chk({tag, ".wdata"}, csr_wdata, 32'h0);
    chk({tag, ".rpc"}, redirect_pc, 32'h0);
  endtask

  initial begin
    int mode;
    logic [31:0] p;
    rst = 1'b0; irq = 1'b0; mret = 1'b0; pc = '0;
    ld_ms = '0; ld_mie = '0; ld_mepc = '0;
    e_ms = '0; e_mie = '0; e_mepc = '0;
    idle(3);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Accepted interrupt
    load(32'h8, 32'h800, 32'h0);
    pc = 32'h40; irq = 1'b1;
    predict_trap(32'h40); push_idle();
    play("trap", -1, 0);
    chk_csrs("trap");
    chk("trap.ms_abs", m_ms, 32'h1880);
    idle(RG + 4);

    // MIE clear: rejection, gap, re-check, rejected again
    load(32'h0, 32'h800, 32'h0);
    irq = 1'b1;
    predict_trap(32'h40);
    for (int i = 0; i < RG; i++) push_idle();
    predict_trap(32'h40); push_idle();
    play("gap", -1, RG + 2);
    chk_csrs("gap");
    idle(RG + 4);

    // mret
    load(32'h1880, 32'h800, 32'h44);
    mret = 1'b1;
    predict_mret(); push_idle();
    play("mret", 0, -1);
    chk_csrs("mret");
    chk("mret.ms_abs", m_ms, 32'h88);
    idle(2);

    // irq and mret together: mret first, trap starts right after REDIR
    load(32'h1880, 32'h800, 32'h44);
    pc = 32'h80; irq = 1'b1; mret = 1'b1;
    predict_mret(); predict_trap(32'h80); push_idle();
    play("both", 0, 5);
    chk_csrs("both");
    idle(RG + 4);

    // MEIE clear: two reads, rejection
    load(32'h8, 32'h0, 32'h0);
    irq = 1'b1;
    predict_trap(32'h40); push_idle();
    play("meie", -1, 0);
    chk_csrs("meie");
    idle(RG + 4);

    // Reset while the mepc write is on the port
    load(32'h8, 32'h800, 32'h0);
    p = $urandom & 32'hFFFF_FFFC;
    pc = p; irq = 1'b1;
    predict_trap(p);
    q = q[0:2];
    play("rstepc", -1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstepc.wr", {31'b0, csr_wr}, 32'h1);
    chk("rstepc.addr", {20'b0, csr_addr}, 32'h341);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_all_zero("rstepc.after");
    e_mepc = p; e_ms = 32'h8;
    chk_csrs("rstepc");
    idle(2);

    // Randomized sequences
    for (int it = 0; it < 40; it++) begin
      load($urandom, $urandom, $urandom & 32'hFFFF_FFFC);
      mode = int'($urandom_range(0, 2));
      pc = $urandom & 32'hFFFF_FFFC;
      if (mode == 0) begin
        irq = 1'b1; predict_trap(pc); push_idle();
        play($sformatf("rnd%0d.irq", it), -1, 0);
      end else if (mode == 1) begin
        mret = 1'b1; predict_mret(); push_idle();
        play($sformatf("rnd%0d.mret", it), 0, -1);
      end else begin
        irq = 1'b1; mret = 1'b1; predict_mret(); predict_trap(pc); push_idle();
        play($sformatf("rnd%0d.both", it), 0, 5);
      end
      chk_csrs($sformatf("rnd%0d", it));
      idle(RG + 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
